// File: rtl/mem_bus_arbiter_if.sv
// Valid/ready memory bus bundle shared by both masters and the slave side of the arbiter.
// Latency: none; this is only a signal bundle.
// Backpressure: the requester holds valid and the request fields until the responder pulses ready.
interface mem_bus_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    // Requester side: drives the request, receives the completion
    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    // Responder side: receives the request, drives the completion
    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master (M0 CPU, M1 loader/debug) to one-slave arbiter; one registered transaction at a time. Optional abort: ARB_TIMEOUT_EN.
// Latency: s_valid rises on the edge after a request is seen in IDLE; m*_ready pulses one cycle after s_ready is sampled.
// Backpressure: BUSY holds s_* stable until s_ready (or timeout abort); the losing master keeps valid high and is served next.
module mem_bus_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    mem_bus_arbiter_if.master s,
    output logic              grant_id,
    output logic              timeout_flag
);
    localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    req_t        m0_req, m1_req;
    logic        s_vld_q, s_vld_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [1:0]  m_rdy_q, m_rdy_d;
    logic [31:0] m0_rdat_q, m0_rdat_d;
    logic [31:0] m1_rdat_q, m1_rdat_d;
    logic        tflag_q, tflag_d;
    logic        win;
    logic        timeout_hit;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    assign m0_req = {m0.addr, m0.wdata, m0.wstrb};
    assign m1_req = {m1.addr, m1.wdata, m1.wstrb};

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    // Abort fires in the TIMEOUT_CYCLES-th BUSY cycle; s_ready in that cycle still wins
    assign timeout_hit = (cnt_q == CNT_LAST);

    // Busy-cycle counter: held at zero outside a transaction so it starts clean on every grant
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Winner selection: single requester wins outright; a tie goes to M0 or to the master not served last
    always_comb begin
        win = 1'b0;
        if (m0.valid && m1.valid) begin
            win = FIXED_PRIORITY ? 1'b0 : ~last_q;
        end else begin
            win = m1.valid;
        end
    end

    // Next-state and next-output computation for the IDLE/BUSY/RESP transaction sequencer
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        s_vld_d   = s_vld_q;
        grant_d   = grant_q;
        last_d    = last_q;
        m_rdy_d   = 2'b00;
        m0_rdat_d = m0_rdat_q;
        m1_rdat_d = m1_rdat_q;
        tflag_d   = tflag_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.valid || m1.valid) begin
                    state_d = ST_BUSY;
                    s_vld_d = 1'b1;
                    grant_d = win;
                    last_d  = win;
                    req_d   = win ? m1_req : m0_req;
                end
            end
            ST_BUSY: begin
                if (s.ready || timeout_hit) begin
                    state_d = ST_RESP;
                    s_vld_d = 1'b0;
                    m_rdy_d = grant_q ? 2'b10 : 2'b01;
                    if (!s.ready) begin
                        tflag_d = 1'b1;
                    end
                    if (grant_q) begin
                        m1_rdat_d = s.ready ? s.rdata : ABORT_RDATA;
                    end else begin
                        m0_rdat_d = s.ready ? s.rdata : ABORT_RDATA;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                s_vld_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and all registered outputs; reset drops the slave request immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            s_vld_q   <= 1'b0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            m_rdy_q   <= 2'b00;
            m0_rdat_q <= '0;
            m1_rdat_q <= '0;
            tflag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            s_vld_q   <= s_vld_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            m_rdy_q   <= m_rdy_d;
            m0_rdat_q <= m0_rdat_d;
            m1_rdat_q <= m1_rdat_d;
            tflag_q   <= tflag_d;
        end
    end

    assign s.valid      = s_vld_q;
    assign s.addr       = req_q.addr;
    assign s.wdata      = req_q.wdata;
    assign s.wstrb      = req_q.wstrb;
    assign m0.ready     = m_rdy_q[0];
    assign m1.ready     = m_rdy_q[1];
    assign m0.rdata     = m0_rdat_q;
    assign m1.rdata     = m1_rdat_q;
    assign grant_id     = grant_q;
    assign timeout_flag = tflag_q;
endmodule
